// File: rtl/motion_map_filter.sv
// rtl/motion_map_filter.sv - 3x3 majority filter over a raster-ordered binary motion stream
// Optional per-frame motion pixel count when MOTION_MAP_FILTER_STATS_EN is defined.
module motion_map_filter #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 4,
    parameter int MIN_COUNT  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in_valid,
    output logic in_ready,
    input  logic frame_start,
    input  logic motion_in,
    output logic out_valid,
    output logic motion_out,
    output logic out_last
`ifdef MOTION_MAP_FILTER_STATS_EN
    ,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] motion_count,
    output logic                                      count_valid
`endif
);
    localparam int W    = IMG_WIDTH;
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int TW   = 2 * W + 2;
    localparam int PW   = $clog2(NPIX);
    localparam int CW   = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   taps_q, taps_d;
    logic [PW-1:0]   in_idx_q, in_idx_d;
    logic [PW-1:0]   out_idx_q, out_idx_d;
    logic [CW-1:0]   out_col_q, out_col_d;
    logic            out_valid_q, out_valid_d;
    logic            motion_out_q, motion_out_d;
    logic            out_last_q, out_last_d;

    logic            accept;
    logic            emit;
    logic            new_bit;
    logic [TW:0]     sh;
    logic            left_ok, right_ok;
    logic [8:0]      win;
    logic [3:0]      cnt;
    logic            filt;

    assign in_ready   = (state_q != S_FLUSH);
    assign out_valid  = out_valid_q;
    assign motion_out = motion_out_q;
    assign out_last   = out_last_q;

    always_comb begin
        state_d      = state_q;
        taps_d       = taps_q;
        in_idx_d     = in_idx_q;
        out_idx_d    = out_idx_q;
        out_col_d    = out_col_q;
        out_valid_d  = 1'b0;
        motion_out_d = 1'b0;
        out_last_d   = 1'b0;
        emit         = 1'b0;
        accept       = in_valid && in_ready;
        // During flush zeros are shifted in, which doubles as the bottom padding.
        new_bit      = (state_q == S_FLUSH) ? 1'b0 : motion_in;
        sh           = {taps_q, new_bit};

        case (state_q)
            S_IDLE: begin
                if (accept && frame_start) begin
                    taps_d    = {{(TW-1){1'b0}}, motion_in};
                    in_idx_d  = PW'(1);
                    out_idx_d = '0;
                    out_col_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (frame_start) begin
                        taps_d    = {{(TW-1){1'b0}}, motion_in};
                        in_idx_d  = PW'(1);
                        out_idx_d = '0;
                        out_col_d = '0;
                    end else begin
                        taps_d   = sh[TW-1:0];
                        in_idx_d = in_idx_q + PW'(1);
                        emit     = (in_idx_q >= PW'(W + 1));
                        if (in_idx_q == PW'(NPIX - 1)) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                taps_d = sh[TW-1:0];
                emit   = 1'b1;
                if (out_idx_q == PW'(NPIX - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // sh[W+1] is the centre; sh[2W+2..2W] the row above, sh[2..0] the row below.
        left_ok  = (out_col_q != '0);
        right_ok = (out_col_q != CW'(W - 1));
        win = {sh[2*W+2] & left_ok, sh[2*W+1], sh[2*W] & right_ok,
               sh[W+2]   & left_ok, sh[W+1],   sh[W]   & right_ok,
               sh[2]     & left_ok, sh[1],     sh[0]   & right_ok};
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'b000, win[i]};
        end
        filt = enable ? (cnt >= 4'(MIN_COUNT)) : sh[W+1];

        if (emit) begin
            out_valid_d  = 1'b1;
            motion_out_d = filt;
            out_last_d   = (out_idx_q == PW'(NPIX - 1));
            out_idx_d    = out_idx_q + PW'(1);
            out_col_d    = (out_col_q == CW'(W - 1)) ? '0 : out_col_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            taps_q       <= '0;
            in_idx_q     <= '0;
            out_idx_q    <= '0;
            out_col_q    <= '0;
            out_valid_q  <= 1'b0;
            motion_out_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            out_col_q    <= out_col_d;
            out_valid_q  <= out_valid_d;
            motion_out_q <= motion_out_d;
            out_last_q   <= out_last_d;
        end
    end

`ifdef MOTION_MAP_FILTER_STATS_EN
    localparam int SW = $clog2(NPIX + 1);

    logic [SW-1:0] run_cnt_q, run_cnt_d;
    logic [SW-1:0] motion_count_q, motion_count_d;
    logic          count_valid_q, count_valid_d;

    assign motion_count = motion_count_q;
    assign count_valid  = count_valid_q;

    always_comb begin
        run_cnt_d      = run_cnt_q;
        motion_count_d = motion_count_q;
        count_valid_d  = out_last_q;
        // run_cnt_q already includes the final pixel when out_last is visible.
        if (out_last_q) begin
            motion_count_d = run_cnt_q;
        end
        if (accept && frame_start) begin
            run_cnt_d = '0;
        end else if (emit && filt) begin
            run_cnt_d = run_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q      <= '0;
            motion_count_q <= '0;
            count_valid_q  <= 1'b0;
        end else begin
            run_cnt_q      <= run_cnt_d;
            motion_count_q <= motion_count_d;
            count_valid_q  <= count_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_motion_map_filter.sv
// tb/tb_motion_map_filter.sv - randomized self-checking bench for motion_map_filter
module tb_motion_map_filter;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int MINC = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic in_valid = 1'b0;
    logic frame_start = 1'b0;
    logic motion_in = 1'b0;
    logic in_ready, out_valid, motion_out, out_last;
`ifdef MOTION_MAP_FILTER_STATS_EN
    logic [$clog2(N+1)-1:0] motion_count;
    logic                   count_valid;
`endif

    motion_map_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_COUNT(MINC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .frame_start(frame_start), .motion_in(motion_in), .out_valid(out_valid),
        .motion_out(motion_out), .out_last(out_last)
`ifdef MOTION_MAP_FILTER_STATS_EN
        , .motion_count(motion_count), .count_valid(count_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    bit frm[N];
    int acc_cyc[$];
    int out_cyc[$];
    int out_val[$];
    int out_lst[$];
    int cnt_seen[$];
    int ready_low;
    bit last_seen;

    always @(negedge clk) begin
        if (rst) begin
            if (!in_ready) ready_low++;
            if (out_valid) begin
                out_cyc.push_back(cyc);
                out_val.push_back(int'(motion_out));
                out_lst.push_back(int'(out_last));
                if (out_last) last_seen = 1'b1;
            end
`ifdef MOTION_MAP_FILTER_STATS_EN
            if (count_valid) cnt_seen.push_back(int'(motion_count));
`endif
        end
    end

    // Reference: direct 2D neighbourhood count with out-of-frame neighbours as zero.
    function automatic int model_pix(input bit en, input int k);
        int r = k / W;
        int c = k % W;
        int s = 0;
        if (!en) return int'(frm[k]);
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) s += int'(frm[rr*W + cc]);
            end
        end
        return (s >= MINC) ? 1 : 0;
    endfunction

    task automatic clear_mon();
        acc_cyc.delete(); out_cyc.delete(); out_val.delete(); out_lst.delete(); cnt_seen.delete();
        ready_low = 0;
        last_seen = 1'b0;
    endtask

    task automatic drive_pix(input bit b, input bit fs, input bit gaps, input bit rec);
        int guard = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
        while (!in_ready && guard < 100) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 0, 1);
        in_valid    = 1'b1;
        frame_start = fs;
        motion_in   = b;
        if (rec) acc_cyc.push_back(cyc);
    endtask

    task automatic idle_bus();
        @(posedge clk); #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        motion_in   = 1'b0;
    endtask

    task automatic wait_last(input string tag);
        for (int i = 0; i < 300 && !last_seen; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check({tag, " last_seen"}, int'(last_seen), 1);
    endtask

    task automatic verify(input string tag, input bit en, input bit timing);
        int bad_last = 0;
        int bad_t = 0;
        int ones = 0;
        check({tag, " n_out"}, out_val.size(), N);
        if (out_val.size() == N) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("%s val[%0d]", tag, k), out_val[k], model_pix(en, k));
                ones += model_pix(en, k);
                if (out_lst[k] != ((k == N-1) ? 1 : 0)) bad_last++;
            end
            check({tag, " out_last_pos"}, bad_last, 0);
            if (timing && acc_cyc.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    if (k < N-W-1) begin
                        if (out_cyc[k] != acc_cyc[k+W+1] + 1) bad_t++;
                    end else if (out_cyc[k] != out_cyc[k-1] + 1) begin
                        bad_t++;
                    end
                end
                check({tag, " timing"}, bad_t, 0);
                check({tag, " ready_low"}, ready_low, W + 1);
            end
        end
`ifdef MOTION_MAP_FILTER_STATS_EN
        check({tag, " stats_n"}, cnt_seen.size(), 1);
        if (cnt_seen.size() == 1) check({tag, " motion_count"}, cnt_seen[0], ones);
`endif
    endtask

    task automatic run_frame(input string tag, input bit en, input bit gaps, input int junk);
        clear_mon();
        enable = en;
        for (int j = 0; j < junk; j++) drive_pix(1'($urandom_range(0, 1)), 1'b0, gaps, 1'b0);
        for (int k = 0; k < N; k++) drive_pix(frm[k], (k == 0), gaps, 1'b1);
        idle_bus();
        wait_last(tag);
        verify(tag, en, 1'b1);
    endtask

    task automatic fill(input int density);
        for (int k = 0; k < N; k++) frm[k] = ($urandom_range(0, 99) < density);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ea0, ea1;
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst motion_out", int'(motion_out), 0);
        check("rst out_last", int'(out_last), 0);
        check("rst in_ready", int'(in_ready), 1);
`ifdef MOTION_MAP_FILTER_STATS_EN
        check("rst motion_count", int'(motion_count), 0);
        check("rst count_valid", int'(count_valid), 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        fill(0);
        run_frame("zero", 1'b1, 1'b0, 0);

        fill(0);
        frm[1*W + 3] = 1'b1;
        run_frame("single", 1'b1, 1'b0, 0);

        fill(100);
        run_frame("ones", 1'b1, 1'b0, 0);

        fill(0);
        frm[2*W + 5] = 1'b1;
        run_frame("bypass", 1'b0, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            fill(int'($urandom_range(20, 80)));
            run_frame($sformatf("rand%0d", t), 1'($urandom_range(0, 3) != 0), 1'b1, int'($urandom_range(0, 3)));
        end

        // Resync: 11 pixels of an aborted frame, then a complete new frame.
        clear_mon();
        enable = 1'b1;
        fill(50);
        for (int k = 11; k < N; k++) frm[k] = 1'b0;
        ea0 = model_pix(1'b1, 0);
        ea1 = model_pix(1'b1, 1);
        for (int k = 0; k < 11; k++) drive_pix(frm[k], (k == 0), 1'b0, 1'b0);
        fill(60);
        for (int k = 0; k < N; k++) drive_pix(frm[k], (k == 0), 1'b0, 1'b0);
        idle_bus();
        wait_last("resync");
        check("resync n_out", out_val.size(), N + 2);
        if (out_val.size() == N + 2) begin
            int bad_last = 0;
            check("resync old0", out_val[0], ea0);
            check("resync old1", out_val[1], ea1);
            for (int k = 0; k < N; k++) begin
                check($sformatf("resync val[%0d]", k), out_val[k+2], model_pix(1'b1, k));
            end
            for (int k = 0; k < N + 2; k++) if (out_lst[k] != ((k == N+1) ? 1 : 0)) bad_last++;
            check("resync out_last_pos", bad_last, 0);
        end

        // Reset asserted while flushing.
        clear_mon();
        fill(100);
        for (int k = 0; k < N; k++) drive_pix(frm[k], (k == 0), 1'b0, 1'b0);
        idle_bus();
        check("flush in_ready", int'(in_ready), 0);
        @(posedge clk); #2;
        check("flush out_valid", int'(out_valid), 1);
        rst = 1'b0;
        #1;
        check("rstflush out_valid", int'(out_valid), 0);
        check("rstflush in_ready", int'(in_ready), 1);
        check("rstflush out_last", int'(out_last), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        fill(100);
        run_frame("after_rst", 1'b1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
